add_seq: RTL and testbench

ADD_SEQ -- requirements
Module: add_seq

---
 rtl/add_seq_pkg.sv | 13 +
 rtl/add_seq_add_chunk.sv | 31 +++
 rtl/add_seq.sv | 124 ++++++++++++
 tb/tb_add_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared definitions for the chunked sequential adder: FSM encoding and default sizes.
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_seq_state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

endpackage

// File: rtl/add_seq_add_chunk.sv
// CHUNK-bit ripple-carry adder built from full adders; also exposes the carry into the MSB.
module add_chunk
    import add_seq_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] A,
    input  logic [CHUNK-1:0] B,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);

    // Each stage owns its own carry nets so the ripple chain is not one self-referencing vector.
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        logic w_ci;
        logic w_co;
        if (i == 0) begin : g_first
            assign w_ci = c_in;
        end else begin : g_next
            assign w_ci = g_fa[i-1].w_co;
        end
        assign sum[i] = A[i] ^ B[i] ^ w_ci;
        assign w_co   = (A[i] & B[i]) | (w_ci & (A[i] ^ B[i]));
    end

    assign c_out = g_fa[CHUNK-1].w_co;
    assign c_msb = g_fa[CHUNK-1].w_ci;

endmodule

// File: rtl/add_seq.sv
// Sequential adder processing CHUNK bits per cycle over WIDTH-bit operands.
// Optional subtraction (port sub) is enabled by defining ADD_SEQ_SUB_EN.
module add_seq
    import add_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
`ifdef ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_cfg
        $error("add_seq: WIDTH must be a positive integer multiple of CHUNK");
    end

    add_seq_state_t r_state;
    add_seq_state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic             w_sub;
    logic             w_accept;
    logic             w_last;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_sum_chunk;
    logic             w_cout_chunk;
    logic             w_cmsb_chunk;

`ifdef ADD_SEQ_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_accept  = start && (r_state == IDLE || r_state == DONE);
    assign w_last    = (r_idx == LAST_IDX);
    assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];

    add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
        .A     (w_a_chunk),
        .B     (w_b_chunk),
        .c_in  (r_carry),
        .sum   (w_sum_chunk),
        .c_out (w_cout_chunk),
        .c_msb (w_cmsb_chunk)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1, so the captured carry is forced high.
            r_a     <= A;
            r_b     <= w_sub ? ~B : B;
            r_carry <= w_sub ? 1'b1 : c_in;
            r_sum   <= '0;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum[r_idx*CHUNK +: CHUNK] <= w_sum_chunk;
            r_carry <= w_cout_chunk;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_cout_chunk;
                r_ovf  <= w_cmsb_chunk ^ w_cout_chunk;
            end
        end
    end

    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);
    assign sum   = r_sum;
    assign c_out = r_cout;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_add_seq.sv
// Directed self-checking bench for add_seq (32/8 instance plus an 8/8 single-chunk instance).
module tb_add_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        c_in = 1'b0;
    logic        sub = 1'b0;
    logic        busy, done, c_out, ovf;
    logic [31:0] sum;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        c_in8 = 1'b0;
    logic        busy8, done8, c_out8, ovf8;
    logic [7:0]  sum8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    add_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .c_in  (c_in),
`ifdef ADD_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    add_seq #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .c_in  (c_in8),
`ifdef ADD_SEQ_SUB_EN
        .sub   (1'b0),
`endif
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .c_out (c_out8),
        .ovf   (ovf8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive a request, let the accepting edge pass, then scramble the inputs.
    task automatic start_op(input logic [31:0] ia, input logic [31:0] ib,
                            input logic icin, input logic isub);
        @(negedge clk);
        a = ia; b = ib; c_in = icin; sub = isub; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; c_in = ~icin; sub = ~isub;
    endtask

    // Counts falling edges until done is seen; returns at that falling edge.
    task automatic wait_done(input string tag, output int lat, output int busy_cyc);
        lat = 0;
        busy_cyc = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cyc++;
            if (done) break;
        end
        if (!done) check({tag, "_timeout"}, 64'(done), 64'd1);
    endtask

    task automatic check_result(input string tag, input logic [31:0] es,
                                input logic ec, input logic eo);
        check({tag, "_sum"},  64'(sum),   64'(es));
        check({tag, "_cout"}, 64'(c_out), 64'(ec));
        check({tag, "_ovf"},  64'(ovf),   64'(eo));
    endtask

    initial begin
        int lat, bc, saw_done;

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum",  64'(sum),  64'd0);
        check("rst_cout", 64'(c_out), 64'd0);
        check("rst_ovf",  64'(ovf),  64'd0);
        rst = 1'b0;

        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_done("wrap", lat, bc);
        check("wrap_lat", 64'(lat), 64'd5);
        check("wrap_busy", 64'(bc), 64'd4);
        check_result("wrap", 32'h0000_0000, 1'b1, 1'b0);

        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_done("povf", lat, bc);
        check_result("povf", 32'h8000_0000, 1'b0, 1'b1);

        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
        wait_done("mix", lat, bc);
        check_result("mix", 32'hACF1_3569, 1'b0, 1'b0);

        // start pulsed mid-RUN must be ignored
        start_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        @(negedge clk);
        check("ign_busy", 64'(busy), 64'd1);
        a = 32'hFFFF_0000; b = 32'h0F0F_0F0F; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ign", lat, bc);
        check("ign_lat", 64'(lat), 64'd4);
        check_result("ign", 32'h0000_0030, 1'b0, 1'b0);

        // back-to-back acceptance from DONE
        a = 32'h0000_0100; b = 32'h0000_0200; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done("b2b", lat, bc);
        check("b2b_lat", 64'(lat), 64'd5);
        check_result("b2b", 32'h0000_0300, 1'b0, 1'b0);

        start_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        wait_done("novf", lat, bc);
        check_result("novf", 32'h0000_0001, 1'b1, 1'b1);

        // reset on the second RUN cycle, with a coincident start
        start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check_result("abort", 32'h0000_0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        saw_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        check("abort_quiet", 64'(saw_done), 64'd0);

        start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        wait_done("post", lat, bc);
        check_result("post", 32'h2345_6789, 1'b0, 1'b0);

`ifdef ADD_SEQ_SUB_EN
        start_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        wait_done("sub_neg", lat, bc);
        check("sub_neg_sum",  64'(sum),   64'hFFFF_FFFE);
        check("sub_neg_cout", 64'(c_out), 64'd0);

        start_op(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
        wait_done("sub_pos", lat, bc);
        check("sub_pos_sum",  64'(sum),   64'h0000_0002);
        check("sub_pos_cout", 64'(c_out), 64'd1);
`endif

        // single-chunk instance
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; c_in8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'h5A; b8 = 8'hC3;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (done8) break;
        end
        check("w8_done", 64'(done8), 64'd1);
        check("w8_lat",  64'(lat),   64'd2);
        check("w8_sum",  64'(sum8),  64'h00);
        check("w8_cout", 64'(c_out8), 64'd1);
        check("w8_ovf",  64'(ovf8),  64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
